// File: rtl/dnmr_pkg.sv
// Shared types for the dynamic N-modular-redundancy voter.
// Operating modes, ordered by replica count so that upgrades compare upward.
package dnmr_pkg;

    typedef enum logic [1:0] {
        MODE_SIMPLEX  = 2'd0,
        MODE_TMR      = 2'd1,
        MODE_NMR      = 2'd2,
        MODE_FAILSAFE = 2'd3
    } mode_t;

endpackage

// File: rtl/dnmr_voter_if.sv
// Replica-side bus of the dnmr voter.
// The master drives the replica words and hazard inputs; the slave is the voter.
interface dnmr_voter_if #(
    parameter int N = 5,
    parameter int W = 8
);
    logic           in_valid;
    logic [N*W-1:0] rep_data;
    logic [3:0]     err_rate;
    logic           hazard;
    logic [N-1:0]   en;
    logic [W-1:0]   data_o;
    logic           valid_o;
    logic           no_maj;
    logic [N-1:0]   fault;
    logic [1:0]     state_o;

    modport master (
        output in_valid, rep_data, err_rate, hazard,
        input  en, data_o, valid_o, no_maj, fault, state_o
    );

    modport slave (
        input  in_valid, rep_data, err_rate, hazard,
        output en, data_o, valid_o, no_maj, fault, state_o
    );
endinterface

// File: rtl/dnmr_mode_ctrl.sv
// Mode controller: request decode, downgrade dwell and mode FSM.
// Exposes both the registered mode and the mode it will take at the next edge.
module dnmr_mode_ctrl
    import dnmr_pkg::*;
#(
    parameter int LO_TH = 4,
    parameter int HI_TH = 10,
    parameter int DWELL = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] err_rate,
    input  logic       hazard,
    input  logic       all_fault,
    output mode_t      mode_q,
    output mode_t      mode_d
);
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [3:0] LO_V = 4'(LO_TH);
    localparam logic [3:0] HI_V = 4'(HI_TH);

    logic [DW-1:0] dwell_q, dwell_d;
    logic          hi, lo;
    mode_t         req;

    always_comb begin
        hi = hazard || (err_rate >= HI_V);
        lo = err_rate >= LO_V;
        unique case (1'b1)
            hi:        req = MODE_NMR;
            !hi && lo: req = MODE_TMR;
            default:   req = MODE_SIMPLEX;
        endcase
    end

    // A request at or above the current mode cancels any pending downgrade.
    always_comb begin
        mode_d  = mode_q;
        dwell_d = dwell_q;
        if (mode_q != MODE_FAILSAFE) begin
            if (all_fault) begin
                mode_d  = MODE_FAILSAFE;
                dwell_d = '0;
            end else if (req > mode_q) begin
                mode_d  = req;
                dwell_d = '0;
            end else if (req == mode_q) begin
                dwell_d = '0;
            end else if (dwell_q == DW'(DWELL - 1)) begin
                mode_d  = mode_t'(mode_q - 2'd1);
                dwell_d = '0;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= MODE_SIMPLEX;
            dwell_q <= '0;
        end else begin
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/dnmr_voter.sv
// Dynamic NMR manager: enable allocation, replica sync, majority vote
// and leaky disagreement counters that retire persistently bad replicas.
module dnmr_voter
    import dnmr_pkg::*;
#(
    parameter int N           = 5,
    parameter int W           = 8,
    parameter int LO_TH       = 4,
    parameter int HI_TH       = 10,
    parameter int FAULT_LIMIT = 4,
    parameter int DWELL       = 16,
    parameter int SYNC_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    dnmr_voter_if.slave bus
);
    localparam int CW = $clog2(FAULT_LIMIT + 1);
    localparam int SW = $clog2(SYNC_CYCLES + 1);

    logic [N-1:0]  en_q, en_d;
    logic [N-1:0]  fault_q, fault_d;
    logic [N-1:0]  voter;
    logic [SW-1:0] sync_q [N];
    logic [CW-1:0] cnt_q  [N];
    logic [CW-1:0] cnt_d  [N];
    logic [W-1:0]  data_q, win;
    logic          valid_q, no_maj_q;
    logic          found, do_vote, good;
    int            nv, m;
    mode_t         mode_q, mode_d;

    dnmr_mode_ctrl #(
        .LO_TH (LO_TH),
        .HI_TH (HI_TH),
        .DWELL (DWELL)
    ) u_mode (
        .clk       (clk),
        .rst       (rst),
        .err_rate  (bus.err_rate),
        .hazard    (bus.hazard),
        .all_fault (&fault_d),
        .mode_q    (mode_q),
        .mode_d    (mode_d)
    );

    function automatic logic [N-1:0] alloc(mode_t md, logic [N-1:0] flt);
        logic [N-1:0] r;
        int k, c;
        r = '0;
        c = 0;
        unique case (md)
            MODE_SIMPLEX:  k = 1;
            MODE_TMR:      k = 3;
            MODE_NMR:      k = N;
            MODE_FAILSAFE: k = 0;
        endcase
        for (int i = 0; i < N; i++) begin
            if (!flt[i] && c < k) begin
                r[i] = 1'b1;
                c++;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++)
            voter[i] = en_q[i] && (sync_q[i] == SW'(SYNC_CYCLES));
    end

    // First word (ascending index) backed by a strict majority of voters wins.
    always_comb begin
        nv    = 0;
        m     = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++)
            if (voter[i]) nv++;
        for (int i = 0; i < N; i++) begin
            if (voter[i] && !found) begin
                m = 0;
                for (int j = 0; j < N; j++)
                    if (voter[j] && bus.rep_data[j*W +: W] == bus.rep_data[i*W +: W])
                        m++;
                if (2 * m > nv) begin
                    found = 1'b1;
                    win   = bus.rep_data[i*W +: W];
                end
            end
        end
        do_vote = bus.in_valid && (nv != 0);
        good    = do_vote && found;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (good && voter[i]) begin
                if (bus.rep_data[i*W +: W] != win) begin
                    if (cnt_q[i] != CW'(FAULT_LIMIT)) cnt_d[i] = cnt_q[i] + 1'b1;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
            fault_d[i] = fault_q[i] | (cnt_d[i] == CW'(FAULT_LIMIT));
        end
        en_d = alloc(mode_d, fault_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q     <= N'(1);
            fault_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            no_maj_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= '0;
                sync_q[i] <= '0;
            end
        end else begin
            en_q     <= en_d;
            fault_q  <= fault_d;
            valid_q  <= good;
            no_maj_q <= do_vote && !found;
            if (good) data_q <= win;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (!en_q[i] || !en_d[i])
                    sync_q[i] <= '0;
                else if (sync_q[i] != SW'(SYNC_CYCLES))
                    sync_q[i] <= sync_q[i] + 1'b1;
            end
        end
    end

    assign bus.en      = en_q;
    assign bus.fault   = fault_q;
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.no_maj  = no_maj_q;
    assign bus.state_o = mode_q;

endmodule

// File: tb/tb_dnmr_voter.sv
// Directed bench for dnmr_voter: mode changes, sync, voting, retirement
// and failsafe, with vote outcomes checked through an expectation queue.
module tb_dnmr_voter;
    import dnmr_pkg::*;

    localparam int N = 5;
    localparam int W = 8;

    typedef struct packed {
        logic         v;
        logic         nm;
        logic [W-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb[$];
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dnmr_voter_if #(.N(N), .W(W)) bus ();

    dnmr_voter #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(string tag, logic [N*W-1:0] words,
                        logic v, logic nm, logic [W-1:0] d);
        exp_t e;
        bus.rep_data = words;
        bus.in_valid = 1'b1;
        sb.push_back({v, nm, d});
        tick();
        e = sb.pop_front();
        check({tag, ".valid"}, 32'(bus.valid_o), 32'(e.v));
        check({tag, ".no_maj"}, 32'(bus.no_maj), 32'(e.nm));
        check({tag, ".data"}, 32'(bus.data_o), 32'(e.d));
    endtask

    task automatic check_idle(string tag);
        check({tag, ".en"}, 32'(bus.en), 32'h01);
        check({tag, ".state"}, 32'(bus.state_o), 32'(MODE_SIMPLEX));
        check({tag, ".data"}, 32'(bus.data_o), 32'h0);
        check({tag, ".valid"}, 32'(bus.valid_o), 32'h0);
        check({tag, ".no_maj"}, 32'(bus.no_maj), 32'h0);
        check({tag, ".fault"}, 32'(bus.fault), 32'h0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.rep_data = '0;
        bus.err_rate = 4'd0;
        bus.hazard   = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b1;

        // simplex: replica 0 must sync for two edges before it votes
        vote("sync0", {8'h00, 8'h00, 8'h00, 8'h00, 8'h3C}, 1'b0, 1'b0, 8'h00);
        vote("sync1", {8'h00, 8'h00, 8'h00, 8'h00, 8'h3C}, 1'b0, 1'b0, 8'h00);
        vote("simplex", {8'h00, 8'h00, 8'h00, 8'h00, 8'h3C}, 1'b1, 1'b0, 8'h3C);

        // NMR upgrade; syncing replicas disagree but must not vote yet
        bus.err_rate = 4'd12;
        vote("up", {8'h11, 8'h00, 8'h5A, 8'h5A, 8'hA5}, 1'b1, 1'b0, 8'hA5);
        check("up.en", 32'(bus.en), 32'h1F);
        check("up.state", 32'(bus.state_o), 32'(MODE_NMR));
        vote("nsync1", {8'h11, 8'h00, 8'h5A, 8'h5A, 8'hA5}, 1'b1, 1'b0, 8'hA5);
        vote("nsync2", {8'h11, 8'h00, 8'h5A, 8'h5A, 8'hA5}, 1'b1, 1'b0, 8'hA5);
        vote("nmr", {8'h11, 8'h00, 8'hA5, 8'hA5, 8'hA5}, 1'b1, 1'b0, 8'hA5);

        // replica 3 keeps disagreeing until its counter hits the limit
        vote("r3a", {8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5}, 1'b1, 1'b0, 8'hA5);
        check("r3a.fault", 32'(bus.fault), 32'h00);
        vote("r3b", {8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5}, 1'b1, 1'b0, 8'hA5);
        check("r3b.fault", 32'(bus.fault), 32'h00);
        vote("r3c", {8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5}, 1'b1, 1'b0, 8'hA5);
        check("r3c.fault", 32'(bus.fault), 32'h08);
        check("r3c.en", 32'(bus.en), 32'h17);
        // four voters split 2/2: no majority, retired replica 3 ignored
        vote("even", {8'h00, 8'hC3, 8'h00, 8'hC3, 8'hC3}, 1'b0, 1'b1, 8'hA5);

        // downgrade dwell with a hazard pulse on the 10th edge
        bus.in_valid = 1'b0;
        bus.err_rate = 4'd0;
        for (int i = 0; i < 9; i++) tick();
        check("dw9.state", 32'(bus.state_o), 32'(MODE_NMR));
        bus.hazard = 1'b1;
        tick();
        bus.hazard = 1'b0;
        check("dw10.state", 32'(bus.state_o), 32'(MODE_NMR));
        for (int i = 0; i < 15; i++) tick();
        check("dw25.state", 32'(bus.state_o), 32'(MODE_NMR));
        tick();
        check("dw26.state", 32'(bus.state_o), 32'(MODE_TMR));
        check("dw26.en", 32'(bus.en), 32'h07);
        for (int i = 0; i < 15; i++) tick();
        check("dw41.state", 32'(bus.state_o), 32'(MODE_TMR));
        tick();
        check("dw42.state", 32'(bus.state_o), 32'(MODE_SIMPLEX));
        check("dw42.en", 32'(bus.en), 32'h01);

        rst = 1'b0;
        tick();
        check_idle("rst2");
        rst = 1'b1;

        // TMR: retire replica 1, replica 3 takes its place after sync
        bus.err_rate = 4'd5;
        tick();
        check("tmr.state", 32'(bus.state_o), 32'(MODE_TMR));
        check("tmr.en", 32'(bus.en), 32'h07);
        tick();
        tick();
        for (int i = 0; i < 3; i++)
            vote("r1", {8'h00, 8'h00, 8'h77, 8'h88, 8'h77}, 1'b1, 1'b0, 8'h77);
        check("r1.fault", 32'(bus.fault), 32'h00);
        vote("r1d", {8'h00, 8'h00, 8'h77, 8'h88, 8'h77}, 1'b1, 1'b0, 8'h77);
        check("r1d.fault", 32'(bus.fault), 32'h02);
        check("r1d.en", 32'(bus.en), 32'h0D);
        vote("two_ok", {8'h00, 8'h99, 8'h55, 8'h00, 8'h55}, 1'b1, 1'b0, 8'h55);
        vote("two_bad", {8'h00, 8'h55, 8'h66, 8'h00, 8'h55}, 1'b0, 1'b1, 8'h55);
        vote("tmr_nomaj", {8'h00, 8'h02, 8'h01, 8'h00, 8'h03}, 1'b0, 1'b1, 8'h55);
        check("tmr_nomaj.en", 32'(bus.en), 32'h0D);

        // every replica retired: failsafe until reset
        bus.in_valid = 1'b0;
        force dut.fault_q = '1;
        tick();
        release dut.fault_q;
        check("fs.state", 32'(bus.state_o), 32'(MODE_FAILSAFE));
        check("fs.en", 32'(bus.en), 32'h00);
        vote("fs", {8'h12, 8'h12, 8'h12, 8'h12, 8'h12}, 1'b0, 1'b0, 8'h55);
        bus.err_rate = 4'd0;
        bus.hazard   = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("fs_hold.state", 32'(bus.state_o), 32'(MODE_FAILSAFE));
        check("fs_hold.fault", 32'(bus.fault), 32'h1F);
        bus.hazard   = 1'b0;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check_idle("rst3");
        rst = 1'b1;
        tick();
        check("post.fault", 32'(bus.fault), 32'h00);
        check("post.state", 32'(bus.state_o), 32'(MODE_SIMPLEX));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
